eval_sequencer: RTL and testbench

Sequences one word-length evaluation run of the FIR test harness. On a command it pulses the datapath soft reset, waits for the FIR pipelines and the random source to refill, and issues the `start` pulse to the data collectors. It then captures each collector's 64-bit MSE and streams a framed byte packet toward the UART transmitter. It sits between the UART control unit (command side) and the DUT/collector datapath (result side).

---
 rtl/eval_sequencer.sv | 165 ++++++++++++++++
 tb/tb_eval_sequencer.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/eval_sequencer.sv
// Run sequencer for one FIR evaluation: soft reset, pipeline flush, start pulse,
// MSE capture from every collector, then a framed byte packet toward the UART.
module eval_sequencer #(
  parameter int NUM_SYS        = 2,
  parameter int RST_CYCLES     = 4,
  parameter int FLUSH_CYCLES   = 64,
  parameter int TIMEOUT_CYCLES = 2**20
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  output logic                  soft_rstn,
  output logic                  start,
  input  logic [NUM_SYS-1:0]    mse_valid,
  input  logic [NUM_SYS*64-1:0] mse_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic [7:0]            tx_data,
  output logic                  busy,
  output logic                  timeout
);

  localparam int RST_W     = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam int FLUSH_W   = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam int TO_W      = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int NUM_BYTES = 1 + 8 * NUM_SYS;
  localparam int BYTE_W    = $clog2(NUM_BYTES);
  localparam int SLOT_B    = 8 * NUM_SYS;
  localparam int SB_W      = $clog2(SLOT_B);

  localparam logic [RST_W-1:0]   RST_LAST   = RST_W'(RST_CYCLES - 1);
  localparam logic [FLUSH_W-1:0] FLUSH_LAST = FLUSH_W'(FLUSH_CYCLES - 1);
  localparam logic [TO_W-1:0]    TO_LAST    = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [BYTE_W-1:0]  BYTE_LAST  = BYTE_W'(NUM_BYTES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_RESET, S_FLUSH, S_START, S_COLLECT, S_SEND
  } state_t;

  state_t              state_reg, state_next;
  logic [RST_W-1:0]    rst_cnt_reg, rst_cnt_next;
  logic [FLUSH_W-1:0]  flush_cnt_reg, flush_cnt_next;
  logic [TO_W-1:0]     to_cnt_reg, to_cnt_next;
  logic [BYTE_W-1:0]   byte_cnt_reg, byte_cnt_next;
  logic [NUM_SYS-1:0]  flags_reg, flags_next;
  logic [63:0]         slot_reg [NUM_SYS];
  logic [63:0]         slot_next [NUM_SYS];
  logic                timeout_reg, timeout_next;
  logic [7:0]          tx_data_reg, tx_data_next;
  logic                soft_rstn_reg, start_reg, busy_reg, tx_valid_reg;
  logic [7:0]          slot_bytes [SLOT_B];

  // Payload bytes after the header: slot order, each slot MSB first.
  for (genvar gi = 0; gi < NUM_SYS; gi++) begin : g_slot
    for (genvar gj = 0; gj < 8; gj++) begin : g_byte
      assign slot_bytes[8*gi+gj] = slot_reg[gi][63-8*gj -: 8];
    end
  end

  always_comb begin
    state_next     = state_reg;
    rst_cnt_next   = '0;
    flush_cnt_next = '0;
    to_cnt_next    = '0;
    byte_cnt_next  = byte_cnt_reg;
    flags_next     = flags_reg;
    slot_next      = slot_reg;
    timeout_next   = timeout_reg;
    tx_data_next   = tx_data_reg;
    case (state_reg)
      S_IDLE: begin
        if (cmd_valid) begin
          timeout_next = 1'b0;
          flags_next   = '0;
          state_next   = S_RESET;
        end
      end
      S_RESET: begin
        if (rst_cnt_reg == RST_LAST) state_next = S_FLUSH;
        else rst_cnt_next = rst_cnt_reg + 1'b1;
      end
      S_FLUSH: begin
        if (flush_cnt_reg == FLUSH_LAST) state_next = S_START;
        else flush_cnt_next = flush_cnt_reg + 1'b1;
      end
      S_START: state_next = S_COLLECT;
      S_COLLECT: begin
        for (int i = 0; i < NUM_SYS; i++) begin
          if (mse_valid[i] && !flags_reg[i]) begin
            flags_next[i] = 1'b1;
            slot_next[i]  = mse_data[i*64 +: 64];
          end
        end
        to_cnt_next = to_cnt_reg + 1'b1;
        // Strobes in the final cycle count before the timeout decision.
        if (&flags_next) begin
          state_next = S_SEND;
        end else if (to_cnt_reg == TO_LAST) begin
          state_next   = S_SEND;
          timeout_next = 1'b1;
          for (int i = 0; i < NUM_SYS; i++) begin
            if (!flags_next[i]) slot_next[i] = '1;
          end
        end
        if (state_next == S_SEND) begin
          byte_cnt_next = '0;
          tx_data_next  = timeout_next ? 8'hE1 : 8'hA5;
        end
      end
      S_SEND: begin
        if (tx_ready) begin
          if (byte_cnt_reg == BYTE_LAST) begin
            state_next = S_IDLE;
          end else begin
            byte_cnt_next = byte_cnt_reg + 1'b1;
            tx_data_next  = slot_bytes[byte_cnt_reg[SB_W-1:0]];
          end
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg     <= S_IDLE;
      rst_cnt_reg   <= '0;
      flush_cnt_reg <= '0;
      to_cnt_reg    <= '0;
      byte_cnt_reg  <= '0;
      flags_reg     <= '0;
      for (int i = 0; i < NUM_SYS; i++) slot_reg[i] <= '0;
      timeout_reg   <= 1'b0;
      tx_data_reg   <= '0;
      soft_rstn_reg <= 1'b1;
      start_reg     <= 1'b0;
      busy_reg      <= 1'b0;
      tx_valid_reg  <= 1'b0;
    end else begin
      state_reg     <= state_next;
      rst_cnt_reg   <= rst_cnt_next;
      flush_cnt_reg <= flush_cnt_next;
      to_cnt_reg    <= to_cnt_next;
      byte_cnt_reg  <= byte_cnt_next;
      flags_reg     <= flags_next;
      for (int i = 0; i < NUM_SYS; i++) slot_reg[i] <= slot_next[i];
      timeout_reg   <= timeout_next;
      tx_data_reg   <= tx_data_next;
      soft_rstn_reg <= (state_next != S_RESET);
      start_reg     <= (state_next == S_START);
      busy_reg      <= (state_next != S_IDLE);
      tx_valid_reg  <= (state_next == S_SEND);
    end
  end

  assign cmd_ready = (state_reg == S_IDLE);
  assign soft_rstn = soft_rstn_reg;
  assign start     = start_reg;
  assign busy      = busy_reg;
  assign tx_valid  = tx_valid_reg;
  assign tx_data   = tx_data_reg;
  assign timeout   = timeout_reg;

endmodule

// File: tb/tb_eval_sequencer.sv
// Bench for eval_sequencer: expected packet bytes are queued when results are
// driven and checked byte by byte as the sequencer hands them off.
module tb_eval_sequencer;

  logic         clk = 1'b0;
  logic         rstn = 1'b0;
  logic         cmd_valid = 1'b0;
  logic         cmd_ready;
  logic         soft_rstn;
  logic         start;
  logic [1:0]   mse_valid = '0;
  logic [127:0] mse_data = '0;
  logic         tx_valid;
  logic         tx_ready = 1'b0;
  logic [7:0]   tx_data;
  logic         busy;
  logic         timeout;

  int n_checks = 0;
  int n_fail = 0;
  logic [7:0] exp_q [$];

  always #5 clk = ~clk;

  eval_sequencer #(
    .NUM_SYS(2), .RST_CYCLES(4), .FLUSH_CYCLES(64), .TIMEOUT_CYCLES(32)
  ) dut (
    .clk(clk), .rstn(rstn), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .soft_rstn(soft_rstn), .start(start), .mse_valid(mse_valid),
    .mse_data(mse_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .tx_data(tx_data), .busy(busy), .timeout(timeout)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_pkt(input logic [7:0] hdr, input logic [63:0] s0, input logic [63:0] s1);
    exp_q.push_back(hdr);
    for (int b = 0; b < 8; b++) exp_q.push_back(s0[63-8*b -: 8]);
    for (int b = 0; b < 8; b++) exp_q.push_back(s1[63-8*b -: 8]);
  endtask

  task automatic strobe(input logic [1:0] mask, input logic [63:0] d0, input logic [63:0] d1);
    mse_valid = mask;
    mse_data  = {d1, d0};
    tick();
    mse_valid = '0;
    mse_data  = '0;
  endtask

  // Issue a command and check the soft-reset / start timing; returns in the start cycle.
  task automatic start_run(input bit hold_cmd, input bit flush_pulse);
    int low_cnt = 0, first_low = 0, start_cnt = 0, start_pos = 0;
    cmd_valid = 1'b1;
    for (int k = 1; k <= 69; k++) begin
      tick();
      if (!hold_cmd) cmd_valid = 1'b0;
      if (k == 1) begin
        n_checks++;
        if ({timeout, busy, cmd_ready} !== 3'b010) begin
          n_fail++;
          $display("FAIL accept_state: {timeout,busy,cmd_ready}=%b required 010", {timeout, busy, cmd_ready});
        end
      end
      if (!soft_rstn) begin
        low_cnt++;
        if (first_low == 0) first_low = k;
      end
      if (start) begin
        start_cnt++;
        start_pos = k;
      end
      if (flush_pulse && k == 30) begin
        mse_valid = 2'b11;
        mse_data  = {2{64'hDEAD_BEEF_DEAD_BEEF}};
      end
      if (flush_pulse && k == 31) begin
        mse_valid = '0;
        mse_data  = '0;
      end
    end
    n_checks++;
    if (low_cnt != 4 || first_low != 1) begin
      n_fail++;
      $display("FAIL soft_rstn_window: low %0d cycles from cycle %0d, required 4 from 1", low_cnt, first_low);
    end
    n_checks++;
    if (start_cnt != 1 || start_pos != 69) begin
      n_fail++;
      $display("FAIL start_pulse: %0d pulses last at cycle %0d, required 1 at 69", start_cnt, start_pos);
    end
  endtask

  // Drain the packet; optionally randomise tx_ready, optionally stop after N transfers.
  task automatic collect_packet(input bit rnd_ready, input int abort_after);
    int xfers = 0;
    int guard = 0;
    bit stalled = 1'b0;
    bit aborted = 1'b0;
    logic [7:0] held = '0;
    logic [7:0] exp_b;
    while (exp_q.size() > 0 && guard < 2000 && !aborted) begin
      tx_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (stalled) begin
        n_checks++;
        if (!tx_valid || tx_data !== held) begin
          n_fail++;
          $display("FAIL stall_hold: tx_valid=%b tx_data=%02h required 1/%02h", tx_valid, tx_data, held);
        end
      end
      stalled = 1'b0;
      if (tx_valid) begin
        if (tx_ready) begin
          exp_b = exp_q.pop_front();
          n_checks++;
          if (tx_data !== exp_b) begin
            n_fail++;
            $display("FAIL tx_byte[%0d]: got %02h required %02h", xfers, tx_data, exp_b);
          end
          xfers++;
        end else begin
          stalled = 1'b1;
          held = tx_data;
        end
      end
      tick();
      guard++;
      if (abort_after > 0 && xfers == abort_after) aborted = 1'b1;
    end
    tx_ready = 1'b0;
    if (!aborted) begin
      n_checks++;
      if (exp_q.size() != 0) begin
        n_fail++;
        $display("FAIL packet_timeout: %0d bytes still expected after %0d cycles", exp_q.size(), guard);
        exp_q.delete();
      end
      n_checks++;
      if ({busy, cmd_ready, tx_valid} !== 3'b010) begin
        n_fail++;
        $display("FAIL packet_end: {busy,cmd_ready,tx_valid}=%b required 010", {busy, cmd_ready, tx_valid});
      end
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({soft_rstn, start, tx_valid, busy, timeout, cmd_ready} !== 6'b100001 || tx_data !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_values: {srn,st,tv,busy,to,rdy}=%b tx_data=%02h required 100001/00",
               {soft_rstn, start, tx_valid, busy, timeout, cmd_ready}, tx_data);
    end
    rstn = 1'b1;
    tick();
    $display("reset: released");
  endtask

  task automatic test_nominal();
    start_run(1'b0, 1'b0);
    repeat (10) tick();
    strobe(2'b01, 64'h0123_4567_89AB_CDEF, 64'h0);
    repeat (9) tick();
    strobe(2'b10, 64'h0, 64'h0000_0000_0000_0042);
    n_checks++;
    if (tx_valid !== 1'b1 || tx_data !== 8'hA5) begin
      n_fail++;
      $display("FAIL nominal_header: tx_valid=%b tx_data=%02h required 1/a5", tx_valid, tx_data);
    end
    push_pkt(8'hA5, 64'h0123_4567_89AB_CDEF, 64'h0000_0000_0000_0042);
    collect_packet(1'b0, 0);
    $display("nominal: packet drained");
  endtask

  task automatic test_simultaneous();
    start_run(1'b0, 1'b0);
    repeat (3) tick();
    strobe(2'b11, 64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888);
    strobe(2'b01, 64'h9999_9999_9999_9999, 64'h0);
    push_pkt(8'hA5, 64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888);
    collect_packet(1'b0, 0);
    $display("simultaneous: both-slot strobe packet drained");
    start_run(1'b0, 1'b0);
    tick();
    strobe(2'b01, 64'hAAAA_0000_AAAA_0001, 64'h0);
    tick();
    strobe(2'b01, 64'hBBBB_0000_BBBB_0002, 64'h0);
    tick();
    strobe(2'b10, 64'h0, 64'hCCCC_0000_CCCC_0003);
    push_pkt(8'hA5, 64'hAAAA_0000_AAAA_0001, 64'hCCCC_0000_CCCC_0003);
    collect_packet(1'b0, 0);
    $display("simultaneous: repeated slot-0 strobe packet drained");
  endtask

  task automatic test_timeout();
    int cyc;
    start_run(1'b0, 1'b0);
    cyc = 69;
    repeat (5) tick();
    cyc += 5;
    strobe(2'b10, 64'h0, 64'h5);
    cyc++;
    while (!tx_valid && cyc < 200) begin
      tick();
      cyc++;
    end
    n_checks++;
    if (cyc != 102) begin
      n_fail++;
      $display("FAIL timeout_latency: tx_valid at cycle %0d required 102", cyc);
    end
    n_checks++;
    if (timeout !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout_flag: got %b required 1", timeout);
    end
    push_pkt(8'hE1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h5);
    collect_packet(1'b0, 0);
    $display("timeout: aborted packet drained");
    start_run(1'b0, 1'b0);
    tick();
    strobe(2'b11, 64'h7, 64'h8);
    push_pkt(8'hA5, 64'h7, 64'h8);
    collect_packet(1'b0, 0);
    $display("timeout: follow-up run drained");
  endtask

  task automatic test_backpressure();
    logic [63:0] v0, v1;
    v0 = {$urandom, $urandom};
    v1 = {$urandom, $urandom};
    start_run(1'b0, 1'b0);
    repeat (2) tick();
    strobe(2'b11, v0, v1);
    push_pkt(8'hA5, v0, v1);
    collect_packet(1'b1, 0);
    $display("backpressure: slots %016h %016h drained", v0, v1);
  endtask

  task automatic test_ignored_inputs();
    start_run(1'b1, 1'b1);
    repeat (4) tick();
    strobe(2'b01, 64'h5555_0000_5555_0000, 64'h0);
    repeat (2) tick();
    strobe(2'b10, 64'h0, 64'h6666_0000_6666_0000);
    push_pkt(8'hA5, 64'h5555_0000_5555_0000, 64'h6666_0000_6666_0000);
    collect_packet(1'b0, 0);
    $display("ignored_inputs: first run drained with cmd_valid held");
    start_run(1'b0, 1'b0);
    tick();
    strobe(2'b11, 64'h1, 64'h2);
    push_pkt(8'hA5, 64'h1, 64'h2);
    collect_packet(1'b0, 0);
    $display("ignored_inputs: back-to-back run drained");
  endtask

  task automatic test_reset_mid_send();
    start_run(1'b0, 1'b0);
    tick();
    strobe(2'b11, 64'h0123_4567_89AB_CDEF, 64'h42);
    push_pkt(8'hA5, 64'h0123_4567_89AB_CDEF, 64'h42);
    collect_packet(1'b0, 5);
    #2;
    rstn = 1'b0;
    #1;
    n_checks++;
    if ({soft_rstn, start, tx_valid, busy, timeout, cmd_ready} !== 6'b100001 || tx_data !== 8'h00) begin
      n_fail++;
      $display("FAIL async_reset: {srn,st,tv,busy,to,rdy}=%b tx_data=%02h required 100001/00",
               {soft_rstn, start, tx_valid, busy, timeout, cmd_ready}, tx_data);
    end
    exp_q.delete();
    #2;
    rstn = 1'b1;
    tick();
    start_run(1'b0, 1'b0);
    tick();
    strobe(2'b11, 64'h7777_8888_9999_AAAA, 64'hBBBB_CCCC_DDDD_EEEE);
    push_pkt(8'hA5, 64'h7777_8888_9999_AAAA, 64'hBBBB_CCCC_DDDD_EEEE);
    collect_packet(1'b0, 0);
    $display("reset_mid_send: fresh packet drained");
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_simultaneous();
    test_timeout();
    test_backpressure();
    test_ignored_inputs();
    test_reset_mid_send();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
